// File: rtl/sram_arbiter.sv
// sram_arbiter
//   N-client request/acknowledge arbiter and access sequencer for a single-port
//   asynchronous SRAM. Each access runs IDLE -> ACCESS (ACCESS_CYCLES clocks)
//   -> RECOVER (one clock, ack pulse) -> IDLE.
//
//   Build option: define SRAM_ARB_CLIENT0_PRIORITY_EN to give client 0 absolute
//   priority. Clients 1..N-1 then round-robin among themselves. Leaving it
//   undefined gives plain round-robin over all clients. Timing is the same in
//   both builds.
//
// Ports
//   clk        : clock
//   rst_n      : asynchronous active-low reset
//   req        : per-client request level, held until ack
//   we         : per-client write select (1 = write)
//   addr       : per-client address, client i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   wdata      : per-client write data, sliced like addr
//   ack        : per-client one-cycle completion pulse
//   rdata      : per-client read data, holds the last read
//   busy       : high whenever the sequencer is not idle
//   sram_addr  : SRAM address pins
//   sram_ce_n  : SRAM chip enable, active-low
//   sram_oe_n  : SRAM output enable, active-low
//   sram_we_n  : SRAM write enable, active-low
//   sram_data  : SRAM data pins, tri-stated unless writing

module sram_arbiter #(
  parameter int NUM_CLIENTS   = 3,
  parameter int ADDR_WIDTH    = 20,
  parameter int DATA_WIDTH    = 32,
  parameter int ACCESS_CYCLES = 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_CLIENTS-1:0]            req,
  input  logic [NUM_CLIENTS-1:0]            we,
  input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] addr,
  input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] wdata,
  output logic [NUM_CLIENTS-1:0]            ack,
  output logic [NUM_CLIENTS*DATA_WIDTH-1:0] rdata,
  output logic                              busy,
  output logic [ADDR_WIDTH-1:0]             sram_addr,
  output logic                              sram_ce_n,
  output logic                              sram_oe_n,
  output logic                              sram_we_n,
  inout  wire  [DATA_WIDTH-1:0]             sram_data
);

  localparam int IDX_W = $clog2(NUM_CLIENTS);
  localparam int CNT_W = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RECOVER = 2'd2
  } state_t;

  state_t state, state_next;

  logic [IDX_W-1:0]      last;
  logic [IDX_W-1:0]      winner;
  logic [IDX_W-1:0]      grant_idx;
  logic                  grant_valid;
  logic                  lat_we;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic [CNT_W-1:0]      count;
  logic                  drive_data;
  logic                  access_done;

  // Round-robin search starting one past the last granted client.
  always_comb begin : arb_search
    int cand;
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = 0;
`ifdef SRAM_ARB_CLIENT0_PRIORITY_EN
    if (req[0]) begin
      grant_valid = 1'b1;
    end else begin
      // last only ever holds 1..N-1 here, so the rotation covers clients 1..N-1.
      for (int k = 1; k < NUM_CLIENTS; k++) begin
        cand = 1 + ((int'(last) - 1 + k) % (NUM_CLIENTS - 1));
        if (!grant_valid && req[cand]) begin
          grant_valid = 1'b1;
          grant_idx   = IDX_W'(cand);
        end
      end
    end
`else
    for (int k = 1; k <= NUM_CLIENTS; k++) begin
      cand = (int'(last) + k) % NUM_CLIENTS;
      if (!grant_valid && req[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = IDX_W'(cand);
      end
    end
`endif
  end

  assign access_done = (state == ACCESS) && (count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Strobes decode straight from the registered state, so an asynchronous
  // reset releases every strobe and the data pins at once.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    sram_ce_n  = 1'b1;
    sram_oe_n  = 1'b1;
    sram_we_n  = 1'b1;
    drive_data = 1'b0;
    ack        = '0;
    case (state)
      IDLE: begin
        if (grant_valid) begin
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        busy      = 1'b1;
        sram_ce_n = 1'b0;
        if (lat_we) begin
          sram_we_n  = 1'b0;
          drive_data = 1'b1;
        end else begin
          sram_oe_n = 1'b0;
        end
        if (count == '0) begin
          state_next = RECOVER;
        end
      end
      RECOVER: begin
        busy        = 1'b1;
        ack[winner] = 1'b1;
        drive_data  = lat_we;
        state_next  = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Grant latching, access counter and read capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last      <= IDX_W'(NUM_CLIENTS - 1);
      winner    <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      count     <= '0;
      rdata     <= '0;
    end else begin
      if (state == IDLE && grant_valid) begin
        winner    <= grant_idx;
        lat_we    <= we[grant_idx];
        lat_addr  <= addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
        lat_wdata <= wdata[grant_idx*DATA_WIDTH +: DATA_WIDTH];
        count     <= CNT_W'(ACCESS_CYCLES - 1);
`ifdef SRAM_ARB_CLIENT0_PRIORITY_EN
        if (grant_idx != '0) begin
          last <= grant_idx;
        end
`else
        last <= grant_idx;
`endif
      end
      if (state == ACCESS && count != '0) begin
        count <= count - 1'b1;
      end
      if (access_done && !lat_we) begin
        rdata[winner*DATA_WIDTH +: DATA_WIDTH] <= sram_data;
      end
    end
  end

  assign sram_addr = lat_addr;
  assign sram_data = drive_data ? lat_wdata : 'z;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter
//   Bench for sram_arbiter (3 clients, ACCESS_CYCLES = 2). Contains a 64-word
//   asynchronous SRAM model on the pins, a transaction-level reference model
//   compared against the DUT on every falling edge, directed scenarios with
//   literal expectations, and a randomized request phase.
//   Honours SRAM_ARB_CLIENT0_PRIORITY_EN the same way the design does.

module tb_sram_arbiter;

  localparam int N  = 3;
  localparam int AW = 20;
  localparam int DW = 32;
  localparam int A  = 2;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N-1:0]    we;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  wire  [N-1:0]    ack;
  wire  [N*DW-1:0] rdata;
  wire             busy;
  wire  [AW-1:0]   sram_addr;
  wire             sram_ce_n;
  wire             sram_oe_n;
  wire             sram_we_n;
  wire  [DW-1:0]   sram_bus;

  int assert_count = 0;
  int fail_count   = 0;

  logic [DW-1:0] sram_mem [64];
  logic          sram_drive;

  sram_arbiter #(
    .NUM_CLIENTS  (N),
    .ADDR_WIDTH   (AW),
    .DATA_WIDTH   (DW),
    .ACCESS_CYCLES(A)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .we       (we),
    .addr     (addr),
    .wdata    (wdata),
    .ack      (ack),
    .rdata    (rdata),
    .busy     (busy),
    .sram_addr(sram_addr),
    .sram_ce_n(sram_ce_n),
    .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n),
    .sram_data(sram_bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Asynchronous SRAM: drives the pins while output-enabled, stores the pin
  // value at each clock edge while write-enabled.
  assign sram_drive = !sram_ce_n && !sram_oe_n && sram_we_n;
  assign sram_bus   = sram_drive ? sram_mem[sram_addr[5:0]] : 'z;

  initial begin : sram_model
    for (int i = 0; i < 64; i++) sram_mem[i] = '0;
    forever begin
      @(posedge clk);
      if (!sram_ce_n && !sram_we_n) sram_mem[sram_addr[5:0]] = sram_bus;
    end
  end

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic apply_stimulus(input int i, input logic r, input logic w,
                                input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[i]             = r;
    we[i]              = w;
    addr[i*AW +: AW]   = a;
    wdata[i*DW +: DW]  = d;
  endtask

  function automatic int ack_index(input logic [N-1:0] a);
    for (int i = 0; i < N; i++) if (a[i]) return i;
    return -1;
  endfunction

  // Arbitration rule expressed as a rotated search over the clients.
  function automatic int model_pick(input logic [N-1:0] r, input int lst);
`ifdef SRAM_ARB_CLIENT0_PRIORITY_EN
    if (r[0]) return 0;
    for (int k = 1; k < N; k++) begin
      int c = 1 + (lst - 1 + k) % (N - 1);
      if (r[c]) return c;
    end
    return -1;
`else
    for (int k = 1; k <= N; k++) begin
      int c = (lst + k) % N;
      if (r[c]) return c;
    end
    return -1;
`endif
  endfunction

  // Transaction-level reference: m_phase counts clocks since the grant
  // (0 = idle, 1..A = strobe held, A+1 = acknowledge cycle).
  int            m_phase;
  int            m_win;
  int            m_last;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata [N];
  logic [DW-1:0] model_mem [64];

  initial begin : model_compare
    logic [N-1:0] exp_ack;
    logic         exp_access;
    int           w;
    for (int i = 0; i < 64; i++) model_mem[i] = '0;
    m_phase = 0; m_win = 0; m_last = N - 1;
    m_we = 1'b0; m_addr = '0; m_wdata = '0;
    for (int i = 0; i < N; i++) m_rdata[i] = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_phase = 0;
        m_last  = N - 1;
        for (int i = 0; i < N; i++) m_rdata[i] = '0;
        check_output("rst_addr", 64'(sram_addr), 64'd0);
      end
      exp_access = (m_phase >= 1) && (m_phase <= A);
      exp_ack    = '0;
      if (m_phase == A + 1) exp_ack[m_win] = 1'b1;
      check_output("busy", 64'(busy), 64'(m_phase != 0));
      check_output("ce_n", 64'(sram_ce_n), 64'(!exp_access));
      check_output("oe_n", 64'(sram_oe_n), 64'(!(exp_access && !m_we)));
      check_output("we_n", 64'(sram_we_n), 64'(!(exp_access && m_we)));
      check_output("ack", 64'(ack), 64'(exp_ack));
      for (int i = 0; i < N; i++)
        check_output("rdata", 64'(rdata[i*DW +: DW]), 64'(m_rdata[i]));
      if (m_phase != 0) check_output("addr", 64'(sram_addr), 64'(m_addr));
      if (m_phase != 0 && m_we) check_output("wr_bus", 64'(sram_bus), 64'(m_wdata));
      if (exp_access && !m_we)
        check_output("rd_bus", 64'(sram_bus), 64'(model_mem[m_addr[5:0]]));
      if (rst_n) begin
        if (m_phase == 0) begin
          w = model_pick(req, m_last);
          if (w >= 0) begin
            m_win   = w;
            m_we    = we[w];
            m_addr  = addr[w*AW +: AW];
            m_wdata = wdata[w*DW +: DW];
`ifdef SRAM_ARB_CLIENT0_PRIORITY_EN
            if (w != 0) m_last = w;
`else
            m_last = w;
`endif
            m_phase = 1;
          end
        end else if (m_phase <= A) begin
          if (m_phase == A) begin
            if (m_we) model_mem[m_addr[5:0]] = m_wdata;
            else      m_rdata[m_win] = model_mem[m_addr[5:0]];
          end
          m_phase++;
        end else begin
          m_phase = 0;
        end
      end
    end
  end

  initial begin : stimulus
    int exp_order [10];
    int drop_at;
    int got;
    int last_ack_cyc;
    int oe_low;
    int idx;

`ifdef SRAM_ARB_CLIENT0_PRIORITY_EN
    exp_order = '{0, 0, 0, 0, 0, 0, 1, 2, 1, 2};
    drop_at   = 6;
`else
    exp_order = '{0, 1, 2, 0, 1, 2, 1, 2, 1, 2};
    drop_at   = 4;
`endif

    rst_n = 1'b0;
    req = '0; we = '0; addr = '0; wdata = '0;
    step(); step();
    check_output("rst_busy", 64'(busy), 64'd0);
    check_output("rst_ack", 64'(ack), 64'd0);
    check_output("rst_strobes", 64'({sram_ce_n, sram_oe_n, sram_we_n}), 64'b111);
    check_output("rst_rdata", 64'(rdata), 64'd0);
    rst_n = 1'b1;

    // Client 1 writes 0xDEADBEEF to 0x00010.
    apply_stimulus(1, 1'b1, 1'b1, 20'h00010, 32'hDEADBEEF);
    for (int c = 1; c <= A + 2; c++) begin
      step();
      if (c <= A) begin
        check_output("wr_we_n", 64'(sram_we_n), 64'd0);
        check_output("wr_data", 64'(sram_bus), 64'hDEADBEEF);
        check_output("wr_addr", 64'(sram_addr), 64'h10);
      end else if (c == A + 1) begin
        check_output("wr_ack", 64'(ack), 64'b010);
        check_output("wr_hold", 64'(sram_bus), 64'hDEADBEEF);
        check_output("wr_rec_we_n", 64'(sram_we_n), 64'd1);
        req[1] = 1'b0;
      end else begin
        check_output("wr_idle", 64'(busy), 64'd0);
      end
    end

    // Client 0 reads it back.
    apply_stimulus(0, 1'b1, 1'b0, 20'h00010, 32'h0);
    for (int c = 1; c <= A + 1; c++) begin
      step();
      if (c <= A) begin
        check_output("rd_oe_n", 64'(sram_oe_n), 64'd0);
      end else begin
        check_output("rd_ack", 64'(ack), 64'b001);
        check_output("rd_data0", 64'(rdata[0*DW +: DW]), 64'hDEADBEEF);
        check_output("rd_data1", 64'(rdata[1*DW +: DW]), 64'd0);
        check_output("rd_data2", 64'(rdata[2*DW +: DW]), 64'd0);
        req[0] = 1'b0;
      end
    end
    step();

    // Repeat the write and reset in the middle of it.
    apply_stimulus(1, 1'b1, 1'b1, 20'h00010, 32'hDEADBEEF);
    step();
    check_output("mid_we_n", 64'(sram_we_n), 64'd0);
    rst_n = 1'b0;
    #1;
    check_output("mid_strobes", 64'({sram_ce_n, sram_oe_n, sram_we_n}), 64'b111);
    check_output("mid_busy", 64'(busy), 64'd0);
    check_output("mid_ack", 64'(ack), 64'd0);
    check_output("mid_rdata0", 64'(rdata[0*DW +: DW]), 64'd0);
    req[1] = 1'b0;
    step(); step();
    rst_n = 1'b1;

    // All three clients reading continuously.
    for (int i = 0; i < N; i++) apply_stimulus(i, 1'b1, 1'b0, 20'h00010, 32'h0);
    got = 0; last_ack_cyc = 0; oe_low = 0;
    for (int cyc = 0; cyc < 200 && got < 10; cyc++) begin
      step();
      if (!sram_oe_n) oe_low++;
      if (ack != '0) begin
        idx = ack_index(ack);
        check_output("rr_grant", 64'(idx), 64'(exp_order[got]));
        check_output("rr_oe_len", 64'(oe_low), 64'(A));
        if (got > 0) check_output("rr_spacing", 64'(cyc - last_ack_cyc), 64'(A + 2));
        last_ack_cyc = cyc;
        oe_low = 0;
        got++;
        if (got == drop_at) req[0] = 1'b0;
        if (got >= 9 && idx >= 0) req[idx] = 1'b0;
      end
    end
    if (got < 10) check_output("rr_timeout", 64'(got), 64'd10);
    req = '0;
    step(); step();

    // Client 2 changes its address after the grant.
    apply_stimulus(2, 1'b1, 1'b0, 20'h00020, 32'h0);
    step();
    check_output("lat_addr", 64'(sram_addr), 64'h20);
    addr[2*AW +: AW] = 20'h00030;
    for (int c = 2; c <= A + 1; c++) begin
      step();
      check_output("lat_addr", 64'(sram_addr), 64'h20);
      if (c == A + 1) begin
        check_output("lat_ack", 64'(ack), 64'b100);
        req[2] = 1'b0;
      end
    end
    step();

    // Randomized traffic; a request is only withdrawn on its own ack.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      step();
      for (int i = 0; i < N; i++) begin
        if (req[i]) begin
          if (ack[i]) begin
            req[i] = 1'($urandom_range(1, 0));
            apply_stimulus(i, req[i], 1'($urandom_range(1, 0)),
                           AW'($urandom_range(63, 0)), $urandom);
          end else if ($urandom_range(7, 0) == 0) begin
            apply_stimulus(i, 1'b1, 1'($urandom_range(1, 0)),
                           AW'($urandom_range(63, 0)), $urandom);
          end
        end else if ($urandom_range(2, 0) == 0) begin
          apply_stimulus(i, 1'b1, 1'($urandom_range(1, 0)),
                         AW'($urandom_range(63, 0)), $urandom);
        end
      end
    end
    for (int cyc = 0; cyc < 20; cyc++) begin
      step();
      for (int i = 0; i < N; i++) if (ack[i]) req[i] = 1'b0;
    end
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
